vegeta_weight_feeder_fp6: RTL and testbench

Streams one FP6 weight tile from the weight buffer into the head of a column of `vegeta_pu_fp6` processing units. It is the transmitter for the PU weight-shift chain: it drives the weight word, the transferring strobe, the double-buffer select and the weight scale. At the end of each tile it flips the buffer select so the next load targets the idle buffer. It sits between the weight SRAM read port and PU row 0 of each array column.

---
 rtl/vegeta_weight_feeder_fp6_pkg.sv | 27 ++
 rtl/vegeta_weight_feeder_fp6_if.sv | 23 ++
 rtl/vegeta_weight_feeder_fp6_meta_mask.sv | 28 ++
 rtl/vegeta_weight_feeder_fp6.sv | 150 +++++++++++++++
 tb/tb_vegeta_weight_feeder_fp6.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vegeta_weight_feeder_fp6_pkg.sv
// Shared vTPU FP6 definitions: lane geometry, feeder FSM states,
// gemm_mode encodings and the E8M0 unity scale.
package vTPU_pkg_fp6;

    localparam int BETA           = 4;
    localparam int MUL_DATAWIDTH  = 6;
    localparam int META_DATA_SIZE = 2;
    localparam int LANE_W         = MUL_DATAWIDTH + META_DATA_SIZE;
    localparam int WORD_W         = BETA * LANE_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } feeder_state_e;

    localparam logic [1:0] DENSE = 2'b00;
    localparam logic [1:0] SP24  = 2'b01;
    localparam logic [1:0] SP14  = 2'b10;

    localparam logic [7:0] E8M0_UNITY = 8'd127;

    function automatic logic is_dense(input logic [1:0] mode);
        return mode == DENSE;
    endfunction

endpackage

// File: rtl/vegeta_weight_feeder_fp6_if.sv
// Weight-buffer word stream: s_valid/s_ready handshake plus s_data.
// master = buffer read side, slave = feeder.
interface vegeta_weight_feeder_fp6_if #(
    parameter int DATA_W = vTPU_pkg_fp6::WORD_W
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/vegeta_weight_feeder_fp6_meta_mask.sv
// Combinational per-lane metadata zeroing. Ports: gemm_mode selects,
// data_in lane-packed word (FP6 low bits, metadata high bits), data_out.
module vegeta_feeder_meta_mask #(
    parameter int BETA           = vTPU_pkg_fp6::BETA,
    parameter int MUL_DATAWIDTH  = vTPU_pkg_fp6::MUL_DATAWIDTH,
    parameter int META_DATA_SIZE = vTPU_pkg_fp6::META_DATA_SIZE
) (
    input  logic [1:0]                                      gemm_mode,
    input  logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] data_in,
    output logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] data_out
);

    import vTPU_pkg_fp6::*;

    localparam int W = MUL_DATAWIDTH + META_DATA_SIZE;

    // Dense tiles carry no sparsity index; stale metadata bits
    // would otherwise steer the PU lane muxes.
    always_comb begin
        data_out = data_in;
        if (is_dense(gemm_mode)) begin
            for (int i = 0; i < BETA; i++) begin
                data_out[i*W+MUL_DATAWIDTH +: META_DATA_SIZE] = '0;
            end
        end
    end

endmodule

// File: rtl/vegeta_weight_feeder_fp6.sv
// FP6 weight-tile feeder: streams ROWS words into the PU shift chain,
// then flips the double-buffer select and pulses tile_done.
// Ports: clk, rst (async high), start/gemm_mode_in/scale_in request,
// s_bus (slave stream), weight_out/weight_transferring_out/i_wb/
// gemm_mode/weight_scale to PU row 0, busy, tile_done.
// Option: VEGETA_FEEDER_SCALE_EN keeps a per-tile weight_scale register.
module vegeta_weight_feeder_fp6 #(
    parameter int BETA           = vTPU_pkg_fp6::BETA,
    parameter int MUL_DATAWIDTH  = vTPU_pkg_fp6::MUL_DATAWIDTH,
    parameter int META_DATA_SIZE = vTPU_pkg_fp6::META_DATA_SIZE,
    parameter int ROWS           = 32
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [1:0]                                      gemm_mode_in,
    input  logic [7:0]                                      scale_in,
    vegeta_weight_feeder_fp6_if.slave                       s_bus,
    output logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] weight_out,
    output logic                                            weight_transferring_out,
    output logic                                            i_wb,
    output logic [1:0]                                      gemm_mode,
    output logic [7:0]                                      weight_scale,
    output logic                                            busy,
    output logic                                            tile_done
);

    import vTPU_pkg_fp6::*;

    localparam int DW    = BETA * (MUL_DATAWIDTH + META_DATA_SIZE);
    localparam int CNT_W = (ROWS > 2) ? $clog2(ROWS) : 1;

    feeder_state_e    state;
    feeder_state_e    state_nxt;
    logic [CNT_W-1:0] row_cnt;
    logic [1:0]       mode_q;
    logic             accept;
    logic             beat;
    logic             last_row;
    logic [DW-1:0]    masked;

    assign s_bus.s_ready = (state == LOAD);
    assign beat          = s_bus.s_valid && (state == LOAD);
    assign last_row      = (row_cnt == CNT_W'(ROWS - 1));

    // tile_done still counts as busy so a new start cannot
    // overlap the cycle in which i_wb is being published.
    assign busy      = (state != IDLE) || tile_done;
    assign gemm_mode = mode_q;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !busy) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (beat && last_row) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    vegeta_feeder_meta_mask #(
        .BETA           (BETA),
        .MUL_DATAWIDTH  (MUL_DATAWIDTH),
        .META_DATA_SIZE (META_DATA_SIZE)
    ) u_meta_mask (
        .gemm_mode (mode_q),
        .data_in   (s_bus.s_data),
        .data_out  (masked)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            mode_q  <= DENSE;
        end else if (accept) begin
            row_cnt <= '0;
            mode_q  <= gemm_mode_in;
        end else if (beat) begin
            row_cnt <= row_cnt + CNT_W'(1);
        end
    end

    // weight_out only moves on a beat so idle cycles present a
    // stable word while transferring is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_out              <= '0;
            weight_transferring_out <= 1'b0;
        end else begin
            weight_transferring_out <= beat;
            if (beat) begin
                weight_out <= masked;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_wb      <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= (state == COMMIT);
            if (state == COMMIT) begin
                i_wb <= ~i_wb;
            end
        end
    end

`ifdef VEGETA_FEEDER_SCALE_EN
    logic [7:0] scale_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_q <= E8M0_UNITY;
        end else if (accept) begin
            scale_q <= scale_in;
        end
    end

    assign weight_scale = scale_q;
`else
    logic unused_scale;

    assign unused_scale = ^scale_in;
    assign weight_scale = E8M0_UNITY;
`endif

endmodule

// File: tb/tb_vegeta_weight_feeder_fp6.sv
// Scoreboard bench for vegeta_weight_feeder_fp6: driver pushes expected
// words, a negedge monitor pops and checks transfers and tile completion.
module tb_vegeta_weight_feeder_fp6;

    localparam int ROWS = 32;
    localparam int BETA = 4;
    localparam int LW   = 8;
    localparam int DW   = BETA * LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    gemm_mode_in = 2'b00;
    logic [7:0]    scale_in = 8'd0;
    logic [DW-1:0] weight_out;
    logic          weight_transferring_out;
    logic          i_wb;
    logic [1:0]    gemm_mode;
    logic [7:0]    weight_scale;
    logic          busy;
    logic          tile_done;

    vegeta_weight_feeder_fp6_if #(.DATA_W(DW)) bus ();

    vegeta_weight_feeder_fp6 #(
        .BETA           (BETA),
        .MUL_DATAWIDTH  (6),
        .META_DATA_SIZE (2),
        .ROWS           (ROWS)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .gemm_mode_in            (gemm_mode_in),
        .scale_in                (scale_in),
        .s_bus                   (bus.slave),
        .weight_out              (weight_out),
        .weight_transferring_out (weight_transferring_out),
        .i_wb                    (i_wb),
        .gemm_mode               (gemm_mode),
        .weight_scale            (weight_scale),
        .busy                    (busy),
        .tile_done               (tile_done)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [DW-1:0] exp_q[$];
    logic [1:0]    exp_mode = 2'b00;
    logic [7:0]    exp_scale = 8'd127;
    int            exp_gap = 0;
    int            done_total = 0;

    int xfer_cnt = 0;
    int gap_cnt = 0;
    int pending = 0;
    int tiles_since_rst = 0;
    bit seen_first = 0;
    bit prev_xfer = 0;
    bit chk_busy_drop = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: each lane is an 8-bit value; dense mode keeps only
    // the FP6 magnitude (value mod 64), sparse modes pass it through.
    function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w,
                                               input logic [1:0] mode);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < BETA; l++) begin
            int lane;
            lane = int'(w[l*LW +: LW]);
            if (mode == 2'b00) lane = lane % 64;
            r[l*LW +: LW] = 8'(lane);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            xfer_cnt = 0;
            gap_cnt = 0;
            pending = 0;
            seen_first = 0;
            prev_xfer = 0;
            tiles_since_rst = 0;
            chk_busy_drop = 0;
        end else begin
            if (chk_busy_drop) begin
                chk("busy_drop", busy, 0);
                chk("done_one_cycle", tile_done, 0);
                chk_busy_drop = 0;
            end
            if (weight_transferring_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_xfer: got word %0h, expected none",
                             weight_out);
                end else begin
                    chk("weight_out", weight_out, exp_q.pop_front());
                end
                chk("gemm_mode", gemm_mode, exp_mode);
                chk("weight_scale", weight_scale, exp_scale);
                xfer_cnt++;
                seen_first = 1;
                gap_cnt += pending;
                pending = 0;
            end else if (seen_first) begin
                pending++;
            end
            if (tile_done) begin
                tiles_since_rst++;
                done_total++;
                chk("done_xfers", xfer_cnt, ROWS);
                chk("done_after_last", prev_xfer, 1);
                chk("done_gap", gap_cnt, exp_gap);
                chk("i_wb", i_wb, tiles_since_rst % 2);
                chk("busy_at_done", busy, 1);
                xfer_cnt = 0;
                gap_cnt = 0;
                pending = 0;
                seen_first = 0;
                chk_busy_drop = 1;
            end
            prev_xfer = weight_transferring_out;
        end
    end

    task automatic run_tile(input logic [1:0] mode, input logic [7:0] scale,
                            input int kind, input int gap_pos,
                            input int gap_len, input bit rnd_valid,
                            input bit extra_starts, input int stop_after);
        int            i;
        int            gaps;
        int            cyc;
        int            hold;
        bit            v;
        bit            rdy;
        logic [DW-1:0] w;
        i = 0;
        gaps = 0;
        cyc = 0;
        hold = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        gemm_mode_in = mode;
        scale_in = scale;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_mode = mode;
`ifdef VEGETA_FEEDER_SCALE_EN
        exp_scale = scale;
`else
        exp_scale = 8'd127;
`endif
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", bus.s_ready, 1);
        while (i < ROWS && i != stop_after && cyc < 400) begin
            v = 1;
            if (gap_len > 0 && i == gap_pos && hold < gap_len) begin
                v = 0;
                hold++;
            end
            if (rnd_valid && $urandom_range(3) == 0) v = 0;
            if (kind == 0) w = DW'(i);
            else if (kind == 1) w = {DW{1'b1}};
            else w = $urandom;
            bus.s_valid = v;
            bus.s_data = w;
            scale_in = 8'($urandom);
            gemm_mode_in = 2'($urandom);
            start = extra_starts && (cyc == 4 || cyc == 19);
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk);
            if (v && rdy) begin
                exp_q.push_back(ref_word(w, mode));
                i++;
            end else if (i > 0) begin
                gaps++;
            end
            #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        start = 1'b0;
        exp_gap = gaps;
        if (cyc >= 400) begin
            n_checks++;
            $display("FAIL beat_timeout: got %0d beats, expected %0d", i, ROWS);
        end
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 20 && done_total < target; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("tile_done_count", done_total, target);
        chk("queue_drained", exp_q.size(), 0);
        chk("scale_hold", weight_scale, exp_scale);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_xfer", weight_transferring_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tile_done, 0);
        chk("rst_iwb", i_wb, 0);
        chk("rst_wout", weight_out, 0);
        chk("rst_mode", gemm_mode, 0);
        chk("rst_scale", weight_scale, 127);
        rst = 1'b0;

        run_tile(2'b01, 8'd120, 0, 0, 0, 0, 0, -1);
        wait_done(1);
        chk("iwb_after_t1", i_wb, 1);

        run_tile(2'b00, 8'd5, 1, 0, 0, 0, 0, -1);
        wait_done(2);
        chk("iwb_after_t2", i_wb, 0);

        run_tile(2'b10, 8'd64, 2, 12, 3, 0, 0, -1);
        wait_done(3);

        run_tile(2'b01, 8'd200, 2, 0, 0, 0, 1, -1);
        wait_done(4);
        chk("iwb_after_t4", i_wb, 0);

        run_tile(2'b00, 8'd33, 2, 0, 0, 1, 0, -1);
        wait_done(5);

        run_tile(2'b01, 8'd90, 2, 0, 0, 0, 0, 10);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", bus.s_ready, 0);
        chk("mid_rst_xfer", weight_transferring_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_iwb", i_wb, 0);
        chk("mid_rst_wout", weight_out, 0);
        chk("mid_rst_mode", gemm_mode, 0);
        chk("mid_rst_scale", weight_scale, 127);
        exp_q.delete();
        exp_scale = 8'd127;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_total, 5);

        run_tile(2'b10, 8'd120, 2, 0, 0, 1, 0, -1);
        wait_done(6);
        chk("iwb_after_rst_tile", i_wb, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
